// File: rtl/audio_frame_sched.sv
// audio_frame_sched: divides clk down to the serdes bit clock, issues the
// once-per-frame dac_adc_valid trigger, buffers one stereo DAC sample from
// an upstream valid/ready source (counting underruns), and re-registers
// captured ADC samples for downstream consumers.
module audio_frame_sched #(
  parameter int CLK_DIV        = 8,
  parameter int BITS_PER_FRAME = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        src_valid,
  input  logic [15:0] src_data_L,
  input  logic [15:0] src_data_R,
  output logic        src_ready,
  output logic        shift_clk,
  output logic        dac_adc_valid,
  output logic [15:0] dac_data_L,
  output logic [15:0] dac_data_R,
  input  logic        adc_in_valid,
  input  logic [15:0] adc_in_L,
  input  logic [15:0] adc_in_R,
  output logic        adc_valid,
  output logic [15:0] adc_L,
  output logic [15:0] adc_R,
  output logic [15:0] underrun_cnt,
  output logic        running
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP
  } state_e;

  localparam int            BW       = $clog2(BITS_PER_FRAME);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_FRAME - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  state_e        state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic          shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;

  logic          hold_full_q, hold_full_d;
  logic [15:0]   hold_L_q, hold_L_d;
  logic [15:0]   hold_R_q, hold_R_d;
  logic [15:0]   dac_L_q, dac_R_q;
  logic [15:0]   dac_L_next, dac_R_next;
  logic          dac_valid_q;
  logic [15:0]   underrun_q, underrun_d;

  logic          adc_valid_q;
  logic [15:0]   adc_L_q, adc_L_d;
  logic [15:0]   adc_R_q, adc_R_d;

  logic          active;
  logic          tick;
  logic          fall_tick;
  logic          wrap;
  logic          trigger;
  logic          accept;

  // Divider terminal count: the bit clock toggles at the end of this cycle.
  assign active    = (state_q != ST_IDLE);
  assign tick      = active && (div_q == DIV_LAST);
  assign fall_tick = tick && shift_q;
  assign wrap      = fall_tick && (bit_q == BIT_LAST);

  // The trigger is decided on the rising toggle of the last bit of a frame,
  // so it leads the frame-start falling edge by CLK_DIV-1 clocks.
  assign trigger   = (state_q == ST_RUN) && tick && !shift_q && (bit_q == BIT_LAST);
  assign accept    = src_valid && !hold_full_q;

  // The new DAC word is visible during the trigger cycle itself and is then
  // held by the register, so it is stable before and during the pulse.
  assign dac_L_next = !trigger ? dac_L_q : (hold_full_q ? hold_L_q : 16'h0000);
  assign dac_R_next = !trigger ? dac_R_q : (hold_full_q ? hold_R_q : 16'h0000);

  // Run/stop sequencing; STOP lets the current frame finish before idling.
  always_comb begin
    // NOTE: default assigned first so every path writes state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      ST_STOP: begin
        if (enable)    state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit clock divider and bit counter; both parked at zero while idle.
  always_comb begin
    div_d   = div_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    if (!active) begin
      div_d   = 8'd0;
      shift_d = 1'b0;
      bit_d   = '0;
    end else if (tick) begin
      div_d   = 8'd0;
      shift_d = !shift_q;
      if (fall_tick) bit_d = wrap ? '0 : bit_q + BIT_ONE;
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  // One-deep hold register and saturating underrun counter.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_L_d    = hold_L_q;
    hold_R_d    = hold_R_q;
    underrun_d  = underrun_q;
    if (trigger) begin
      if (hold_full_q)                 hold_full_d = 1'b0;
      else if (underrun_q != 16'hFFFF) underrun_d  = underrun_q + 16'd1;
    end
    // Only possible when empty, so a sample arriving in the trigger cycle
    // is never consumed by that frame.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_L_d    = src_data_L;
      hold_R_d    = src_data_R;
    end
  end

  // ADC sample capture, independent of the frame state machine.
  always_comb begin
    adc_L_d = adc_L_q;
    adc_R_d = adc_R_q;
    if (adc_in_valid) begin
      adc_L_d = adc_in_L;
      adc_R_d = adc_in_R;
    end
  end

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      div_q       <= 8'd0;
      shift_q     <= 1'b0;
      bit_q       <= '0;
      hold_full_q <= 1'b0;
      hold_L_q    <= 16'h0000;
      hold_R_q    <= 16'h0000;
      dac_L_q     <= 16'h0000;
      dac_R_q     <= 16'h0000;
      dac_valid_q <= 1'b0;
      underrun_q  <= 16'h0000;
      adc_valid_q <= 1'b0;
      adc_L_q     <= 16'h0000;
      adc_R_q     <= 16'h0000;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
      hold_L_q    <= hold_L_d;
      hold_R_q    <= hold_R_d;
      dac_L_q     <= dac_L_next;
      dac_R_q     <= dac_R_next;
      dac_valid_q <= trigger;
      underrun_q  <= underrun_d;
      adc_valid_q <= adc_in_valid;
      adc_L_q     <= adc_L_d;
      adc_R_q     <= adc_R_d;
    end
  end

  assign src_ready     = !hold_full_q;
  assign shift_clk     = shift_q;
  assign dac_adc_valid = dac_valid_q;
  assign dac_data_L    = dac_L_next;
  assign dac_data_R    = dac_R_next;
  assign adc_valid     = adc_valid_q;
  assign adc_L         = adc_L_q;
  assign adc_R         = adc_R_q;
  assign underrun_cnt  = underrun_q;
  assign running       = active;

endmodule
